// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator front-end
package calc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, LONG_HELD = 2'd2} btn_state_t;
endpackage

// File: rtl/debouncer.sv
// debouncer: 2-FF synchronizer followed by a consecutive-cycle debounce counter
module debouncer #(
  parameter int N_DEBOUNCER = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level
);
  localparam int CW = $clog2(N_DEBOUNCER) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(N_DEBOUNCER - 1);
  logic [1:0] sync;
  logic [CW-1:0] db_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      db_cnt <= '0;
      btn_level <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      if (sync[1] == btn_level) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        btn_level <= ~btn_level;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced button classified into short-press enter and long-press undo strobes
module button_conditioner
  import calc_pkg::*;
#(
  parameter int N_DEBOUNCER = 10,
  parameter int N_LONG = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       enter_pulse,
  output logic       undo_pulse,
  output logic [1:0] state_o
);
  localparam int HW = $clog2(N_LONG) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(N_LONG - 1);
  btn_state_t state;
  logic [HW-1:0] hold_cnt;
  debouncer #(.N_DEBOUNCER(N_DEBOUNCER)) u_db (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level)
  );
  assign state_o = state;
  // release is checked before the threshold so a tie yields enter, not undo
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      enter_pulse <= 1'b0;
      undo_pulse <= 1'b0;
    end else begin
      enter_pulse <= 1'b0;
      undo_pulse <= 1'b0;
      case (state)
        IDLE: if (btn_level) begin
          state <= PRESSED;
          hold_cnt <= '0;
        end
        PRESSED: if (!btn_level) begin
          enter_pulse <= 1'b1;
          state <= IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          undo_pulse <= 1'b1;
          state <= LONG_HELD;
        end else if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        LONG_HELD: if (!btn_level) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed presses checked against a run-length reference model
module tb_button_conditioner;
  localparam int ND = 10;
  localparam int NL = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, enter_pulse, undo_pulse;
  logic [1:0] state_o;
  always #2 clk = ~clk;
  button_conditioner #(.N_DEBOUNCER(ND), .N_LONG(NL)) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .enter_pulse(enter_pulse),
    .undo_pulse(undo_pulse),
    .state_o(state_o)
  );
  typedef struct {int cyc; int kind;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0;
  bit s1, s2, lvl, lvl_prev, flip;
  bit hist[$];
  int run = 0, run_prev = 0, exp_state = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask
  // level flips after ND consecutive synchronized samples disagree; a press of
  // L high cycles gives enter if L<=NL, else undo NL+1 cycles after the rise
  initial forever begin
    ev_t e;
    @(posedge clk);
    cyc++;
    if (reset) begin
      s1 = 0; s2 = 0; hist.delete(); lvl = 0; lvl_prev = 0;
      run = 0; run_prev = 0; exp_state = 0;
    end else begin
      exp_state = !lvl ? 0 : (run <= NL ? 1 : 2);
      if (!lvl && lvl_prev && run_prev <= NL) begin
        e.cyc = cyc; e.kind = 1; q.push_back(e);
      end
      if (lvl && run == NL + 1) begin
        e.cyc = cyc; e.kind = 2; q.push_back(e);
      end
      hist.push_back(s2);
      if (hist.size() > ND) void'(hist.pop_front());
      flip = (hist.size() == ND);
      foreach (hist[i]) if (hist[i] == lvl) flip = 0;
      lvl_prev = lvl;
      run_prev = run;
      if (flip) lvl = !lvl;
      run = lvl ? run + 1 : 0;
      s2 = s1;
      s1 = btn_in;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("btn_level", int'(btn_level), int'(lvl));
    chk("state_o", int'(state_o), exp_state);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missed_pulse cycle=%0d got=none want=kind%0d@%0d", cyc, q[0].kind, q[0].cyc);
      void'(q.pop_front());
    end
    if (enter_pulse || undo_pulse) begin
      total++;
      if (enter_pulse && undo_pulse) begin
        bad++;
        $display("FAIL both_pulses cycle=%0d got=enter+undo want=one", cyc);
      end else if (q.size() == 0 || q[0].cyc != cyc || q[0].kind != (enter_pulse ? 1 : 2)) begin
        bad++;
        $display("FAIL pulse cycle=%0d got=kind%0d want=kind%0d@%0d", cyc, enter_pulse ? 1 : 2,
                 q.size() > 0 ? q[0].kind : 0, q.size() > 0 ? q[0].cyc : -1);
      end
      if (q.size() > 0 && q[0].cyc == cyc) void'(q.pop_front());
    end
  end
  task automatic hold(input bit v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold(0, 30);
    hold(1, 15); hold(0, 40);
    repeat (7) begin hold(1, 3); hold(0, 3); end
    hold(0, 30);
    hold(1, 60); hold(0, 40);
    hold(1, 16); pulse_reset(); hold(1, 20); hold(0, 40);
    hold(1, NL); hold(0, 40);
    hold(1, NL + 1); hold(0, 40);
    repeat (40) begin
      hold(1, $urandom_range(1, 45));
      if ($urandom_range(0, 9) == 0) pulse_reset();
      hold(0, $urandom_range(1, 45));
    end
    hold(0, 40);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
